// File: rtl/yuv_block_buffer_pkg.sv
// rtl/yuv_block_buffer_pkg.sv - shared types and helpers for the YUV block buffer
package yuv_buf_pkg;

  localparam int BLK           = 8;
  localparam int ROWS_PER_BLK  = BLK;
  localparam int DEF_PIX_W     = 8;
  localparam int DEF_OUT_PIX_W = 12;

  typedef enum logic [1:0] {
    CH_Y  = 2'd0,
    CH_CB = 2'd1,
    CH_CR = 2'd2
  } chan_e;

  typedef enum logic {
    ST_FILL,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    chan_e      chan;
    logic [2:0] row;
    logic       block_last;
    logic       frame_last;
  } meta_t;

  function automatic logic [DEF_OUT_PIX_W-1:0] pad_lane(input logic [DEF_PIX_W-1:0] pixel);
    return DEF_OUT_PIX_W'(pixel);
  endfunction

endpackage

// File: rtl/yuv_block_buffer_if.sv
// rtl/yuv_block_buffer_if.sv - pixel input and block-word output handshake bundle
interface yuv_block_buffer_if #(
  parameter int OUT_PIX_W = yuv_buf_pkg::DEF_OUT_PIX_W
);
  logic                     in_valid;
  logic                     in_ready;
  logic [15:0]              Y_in;
  logic [15:0]              Cb_in;
  logic [15:0]              Cr_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [8*OUT_PIX_W-1:0]   data_out;
  logic [1:0]               out_chan;
  logic [2:0]               out_row;
  logic                     block_last;
  logic                     frame_last;

  modport master (
    output in_valid, Y_in, Cb_in, Cr_in, out_ready,
    input  in_ready, out_valid, data_out, out_chan, out_row, block_last, frame_last
  );

  modport slave (
    input  in_valid, Y_in, Cb_in, Cr_in, out_ready,
    output in_ready, out_valid, data_out, out_chan, out_row, block_last, frame_last
  );
endinterface

// File: rtl/yuv_block_buffer_row_packer.sv
// rtl/yuv_block_buffer_row_packer.sv - packs 8 pixels of one channel into a row-word
// Optional YUV_ROUND_EN rounds Q8.8 to nearest with saturation instead of truncating.
module yuv_row_packer
  import yuv_buf_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   last,
  input  logic [15:0]            sample,
  output logic                   wr_en,
  output logic [BLK*PIX_W-1:0]   wr_word
);

  logic [PIX_W-1:0]         pix;
  logic [(BLK-1)*PIX_W-1:0] shreg;
  logic                     unused_lsbs;

`ifdef YUV_ROUND_EN
  logic [8:0] rounded;
  always_comb begin
    rounded = {1'b0, sample[15:8]} + 9'(sample[7]);
    pix     = rounded[8] ? {PIX_W{1'b1}} : PIX_W'(rounded[7:0]);
  end
  assign unused_lsbs = ^sample[6:0];
`else
  assign pix         = PIX_W'(sample[15:8]);
  assign unused_lsbs = ^sample[7:0];
`endif

  // Earliest pixel ends up in the MSB lane once the eighth arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg <= '0;
    end else if (push) begin
      shreg <= {shreg[(BLK-2)*PIX_W-1:0], pix};
    end
  end

  assign wr_en   = push && last;
  assign wr_word = {shreg, pix};

endmodule

// File: rtl/yuv_block_buffer.sv
// rtl/yuv_block_buffer.sv - raster-in, 8x8-block-out Y/Cb/Cr frame store
// Build option YUV_ROUND_EN selects rounding instead of truncation of the Q8.8 input.
module yuv_block_buffer
  import yuv_buf_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int HEIGHT    = 32,
  parameter int PIX_W     = DEF_PIX_W,
  parameter int OUT_PIX_W = DEF_OUT_PIX_W
) (
  input  logic               clock,
  input  logic               reset,
  yuv_block_buffer_if.slave  bus
);

  localparam int WPR   = WIDTH / BLK;
  localparam int DEPTH = WPR * HEIGHT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int BXW   = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int BYW   = (HEIGHT / BLK > 1) ? $clog2(HEIGHT / BLK) : 1;
  localparam int RW    = BLK * PIX_W;
  localparam int OW    = BLK * OUT_PIX_W;

  state_e          state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [BXW-1:0]  bx;
  logic [BYW-1:0]  by;
  chan_e           chan;
  logic [2:0]      row;
  logic            issue_done;

  logic [RW-1:0]   mem_y  [DEPTH];
  logic [RW-1:0]   mem_cb [DEPTH];
  logic [RW-1:0]   mem_cr [DEPTH];

  logic            fill_xfer, word_end;
  logic            wr_y, wr_cb, wr_cr;
  logic [RW-1:0]   word_y, word_cb, word_cr;
  logic [AW-1:0]   wr_addr, rd_addr;

  assign fill_xfer = bus.in_valid && (state == ST_FILL);
  assign word_end  = (x[2:0] == 3'd7);
  assign wr_addr   = AW'(32'(y) * WPR + (32'(x) >> 3));
  assign bus.in_ready = (state == ST_FILL);

  yuv_row_packer #(.PIX_W(PIX_W)) u_pack_y (
    .clock(clock), .reset(reset), .push(fill_xfer), .last(word_end),
    .sample(bus.Y_in), .wr_en(wr_y), .wr_word(word_y)
  );
  yuv_row_packer #(.PIX_W(PIX_W)) u_pack_cb (
    .clock(clock), .reset(reset), .push(fill_xfer), .last(word_end),
    .sample(bus.Cb_in), .wr_en(wr_cb), .wr_word(word_cb)
  );
  yuv_row_packer #(.PIX_W(PIX_W)) u_pack_cr (
    .clock(clock), .reset(reset), .push(fill_xfer), .last(word_end),
    .sample(bus.Cr_in), .wr_en(wr_cr), .wr_word(word_cr)
  );

  always_ff @(posedge clock) begin
    if (wr_y)  mem_y[wr_addr]  <= word_y;
    if (wr_cb) mem_cb[wr_addr] <= word_cb;
    if (wr_cr) mem_cr[wr_addr] <= word_cr;
  end

  meta_t           issue_meta, rd_meta, head_meta;
  logic            rd_valid;
  logic [RW-1:0]   rd_word;
  logic [OW-1:0]   rd_padded;
  logic [OW-1:0]   ent_data [2];
  meta_t           ent_meta [2];
  logic            rd_ptr, wr_ptr;
  logic [1:0]      count;
  logic            pop, issue, bx_last, by_last, blk_end;

  assign bx_last = (bx == BXW'(WPR - 1));
  assign by_last = (by == BYW'(HEIGHT / BLK - 1));
  assign blk_end = (chan == CH_CR) && (row == 3'(ROWS_PER_BLK - 1));
  assign rd_addr = AW'((32'(by) * BLK + 32'(row)) * WPR + 32'(bx));
  assign pop     = bus.out_valid && bus.out_ready;

  always_comb begin
    issue_meta            = '0;
    issue_meta.chan       = chan;
    issue_meta.row        = row;
    issue_meta.block_last = blk_end;
    issue_meta.frame_last = blk_end && bx_last && by_last;
  end

  // Credit check counts the word in flight from memory so the 2-entry skid never overflows.
  assign issue = (state == ST_DRAIN) && !issue_done &&
                 ((3'(count) + 3'(rd_valid)) < (3'd2 + 3'(pop)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_FILL;
      x          <= '0;
      y          <= '0;
      bx         <= '0;
      by         <= '0;
      chan       <= CH_Y;
      row        <= '0;
      issue_done <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (fill_xfer) begin
            if (x == XW'(WIDTH - 1)) begin
              x <= '0;
              if (y == YW'(HEIGHT - 1)) begin
                y     <= '0;
                state <= ST_DRAIN;
              end else begin
                y <= y + 1'b1;
              end
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (issue) begin
            row <= row + 1'b1;
            if (row == 3'(ROWS_PER_BLK - 1)) begin
              chan <= (chan == CH_CR) ? CH_Y : chan_e'(chan + 2'd1);
              if (chan == CH_CR) begin
                bx <= bx_last ? '0 : bx + 1'b1;
                if (bx_last) begin
                  by <= by_last ? '0 : by + 1'b1;
                  if (by_last) issue_done <= 1'b1;
                end
              end
            end
          end
          if (pop && head_meta.frame_last) begin
            state      <= ST_FILL;
            issue_done <= 1'b0;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_meta  <= '0;
      rd_word  <= '0;
    end else begin
      rd_valid <= issue;
      if (issue) begin
        rd_meta <= issue_meta;
        case (chan)
          CH_Y:    rd_word <= mem_y[rd_addr];
          CH_CB:   rd_word <= mem_cb[rd_addr];
          default: rd_word <= mem_cr[rd_addr];
        endcase
      end
    end
  end

  always_comb begin
    rd_padded = '0;
    for (int i = 0; i < BLK; i++) begin
      rd_padded[i*OUT_PIX_W +: OUT_PIX_W] = OUT_PIX_W'(rd_word[i*PIX_W +: PIX_W]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      ent_data[0] <= '0;
      ent_data[1] <= '0;
      ent_meta[0] <= '0;
      ent_meta[1] <= '0;
    end else begin
      if (rd_valid) begin
        ent_data[wr_ptr] <= rd_padded;
        ent_meta[wr_ptr] <= rd_meta;
        wr_ptr           <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + 2'(rd_valid) - 2'(pop);
    end
  end

  assign head_meta      = ent_meta[rd_ptr];
  assign bus.out_valid  = (count != 2'd0);
  assign bus.data_out   = ent_data[rd_ptr];
  assign bus.out_chan   = head_meta.chan;
  assign bus.out_row    = head_meta.row;
  assign bus.block_last = head_meta.block_last;
  assign bus.frame_last = head_meta.frame_last;

endmodule

// File: tb/tb_yuv_block_buffer.sv
// tb/tb_yuv_block_buffer.sv - self-checking bench for yuv_block_buffer (16x16 frame)
module tb_yuv_block_buffer;
  import yuv_buf_pkg::*;

  localparam int W     = 16;
  localparam int H     = 16;
  localparam int NPIX  = W * H;
  localparam int NWORD = 3 * H * W / 8;
  localparam int OPW   = DEF_OUT_PIX_W;
  localparam int OW    = 8 * OPW;

  logic clock = 1'b0;
  logic reset = 1'b1;

  yuv_block_buffer_if #(.OUT_PIX_W(OPW)) bus ();

  yuv_block_buffer #(
    .WIDTH(W), .HEIGHT(H), .PIX_W(DEF_PIX_W), .OUT_PIX_W(OPW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [15:0]   raw   [3][NPIX];
  logic [7:0]    pix_m [3][NPIX];
  logic [OW-1:0] got   [NWORD];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] quant(input logic [15:0] v);
`ifdef YUV_ROUND_EN
    int s;
    s = int'(v[15:8]) + int'(v[7]);
    return (s > 255) ? 8'd255 : 8'(s);
`else
    return v[15:8];
`endif
  endfunction

  // Word k of the frame: blocks in raster order, 24 words each (8 Y, 8 Cb, 8 Cr rows).
  function automatic logic [OW-1:0] exp_word(input int k);
    int b, c, r, bxi, byi;
    logic [OW-1:0] w;
    b   = k / 24;
    c   = (k % 24) / 8;
    r   = k % 8;
    bxi = b % (W / 8);
    byi = b / (W / 8);
    w   = '0;
    for (int i = 0; i < 8; i++)
      w[(7-i)*OPW +: OPW] = pad_lane(pix_m[c][(byi*8 + r)*W + bxi*8 + i]);
    return w;
  endfunction

  task automatic make_frame(input int kind);
    for (int n = 0; n < NPIX; n++) begin
      if (kind == 0) begin
        raw[0][n] = {8'(n), 8'h00};
        raw[1][n] = raw[0][n] + 16'h4000;
        raw[2][n] = raw[0][n] + 16'h8000;
      end else begin
        raw[0][n] = 16'($urandom);
        raw[1][n] = 16'($urandom);
        raw[2][n] = 16'($urandom);
      end
    end
    if (kind != 0) begin
      raw[0][0] = 16'h12FF;
      raw[1][0] = 16'hFFFF;
      raw[2][0] = 16'hFF80;
      raw[0][1] = 16'h1280;
    end
    for (int c = 0; c < 3; c++)
      for (int n = 0; n < NPIX; n++)
        pix_m[c][n] = quant(raw[c][n]);
  endtask

  task automatic send_pixels(input int n, input bit gaps);
    int guard;
    for (int p = 0; p < n; p++) begin
      @(negedge clock);
      if (gaps && $urandom_range(3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
      end
      bus.in_valid = 1'b1;
      bus.Y_in     = raw[0][p];
      bus.Cb_in    = raw[1][p];
      bus.Cr_in    = raw[2][p];
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 100) begin
        @(negedge clock);
        guard++;
      end
      if (guard >= 100) chk("in_ready_timeout", 0, 1);
      @(posedge clock);
    end
  endtask

  task automatic drain(input int mode, input bit junk, input int maxw);
    int k = 0, cyc = 0, lat = 0, gaps = 0, bad_ir = 0, stall_bad = 0;
    bit seen = 0, stalled = 0, rdy;
    logic [OW-1:0] hd;
    logic [6:0] hs;
    logic [6:0] sb, esb;
    while (k < maxw && cyc < 4000) begin
      @(negedge clock);
      cyc++;
      sb = {bus.out_chan, bus.out_row, bus.block_last, bus.frame_last};
      if (bus.in_ready !== 1'b0) bad_ir++;
      if (stalled && ({bus.out_valid, bus.data_out, sb} !== {1'b1, hd, hs})) stall_bad++;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(1));
      bus.out_ready = rdy;
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.Y_in     = 16'($urandom);
        bus.Cb_in    = 16'($urandom);
        bus.Cr_in    = 16'($urandom);
      end
      if (bus.out_valid !== 1'b1) begin
        if (!seen) lat++;
        else gaps++;
      end else begin
        seen = 1;
        if (rdy) begin
          esb = {2'((k % 24) / 8), 3'(k % 8), k % 24 == 23, k == NWORD - 1};
          chk($sformatf("word%0d_data", k), bus.data_out, exp_word(k));
          chk($sformatf("word%0d_side", k), sb, esb);
          got[k] = bus.data_out;
          k++;
        end
      end
      stalled = (bus.out_valid === 1'b1) && !rdy;
      hd = bus.data_out;
      hs = sb;
    end
    if (k < maxw) chk("drain_timeout", k, maxw);
    chk("in_ready_low_in_drain", bad_ir, 0);
    chk("stall_stable", stall_bad, 0);
    if (mode == 0) begin
      chk("first_valid_latency", lat, 2);
      chk("no_bubbles", gaps, 0);
    end
    if (maxw == NWORD) begin
      @(negedge clock);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("in_ready_after_last", bus.in_ready, 1);
      chk("out_valid_after_last", bus.out_valid, 0);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_data_out"}, bus.data_out, 0);
    chk({tag, "_out_chan"}, bus.out_chan, 0);
    chk({tag, "_out_row"}, bus.out_row, 0);
    chk({tag, "_block_last"}, bus.block_last, 0);
    chk({tag, "_frame_last"}, bus.frame_last, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [OW-1:0] e;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.Y_in      = '0;
    bus.Cb_in     = '0;
    bus.Cr_in     = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk_reset("reset");

    // Ramp frame, consumer always ready
    make_frame(0);
    send_pixels(NPIX, 0);
    drain(0, 0, NWORD);
    e = '0;
    for (int i = 0; i < 8; i++) e[(7-i)*OPW +: OPW] = OPW'(i);
    chk("ramp_word0", got[0], e);
    e = '0;
    for (int i = 0; i < 8; i++) e[(7-i)*OPW +: OPW] = OPW'(8'h40 + i);
    chk("ramp_word8_cb", got[8], e);
    e = '0;
    for (int i = 0; i < 8; i++) e[(7-i)*OPW +: OPW] = OPW'(8 + i);
    chk("ramp_word24_blk1", got[24], e);

    // Random frame with input gaps, consumer toggling ready
    make_frame(1);
    send_pixels(NPIX, 1);
    drain(1, 0, NWORD);
`ifdef YUV_ROUND_EN
    chk("quant_12FF", got[0][OW-1 -: OPW], OPW'(8'h13));
`else
    chk("quant_12FF", got[0][OW-1 -: OPW], OPW'(8'h12));
`endif
    chk("quant_FFFF", got[8][OW-1 -: OPW], OPW'(8'hFF));
    chk("quant_FF80", got[16][OW-1 -: OPW], OPW'(8'hFF));

    // Reset during FILL, then a fresh frame
    make_frame(1);
    send_pixels(40, 0);
    do_reset();
    chk_reset("rst_fill");
    make_frame(1);
    send_pixels(NPIX, 0);

    // Reset during DRAIN after 10 words, then a fresh frame with input noise during DRAIN
    drain(0, 0, 10);
    do_reset();
    chk_reset("rst_drain");
    make_frame(0);
    send_pixels(NPIX, 1);
    drain(2, 1, NWORD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
